// File: rtl/sync_fifo_pkg.sv
// Shared constants, sizing helper and status bundle for the parametrised sync FIFO.
package sync_fifo_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_AF_LEVEL = 12;
  localparam int DEF_AE_LEVEL = 4;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one read port that is either
// registered (1-cycle latency) or combinational (for first-word-fall-through).
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter bit REG_RD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [depth_of(ADDR_W)];

  // NOTE: storage has no reset so it maps onto RAM macros; only control state is reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (REG_RD) begin : g_reg_rd
      // A same-edge write to raddr is not visible here: the old word is returned.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
      end
    end else begin : g_comb_rd
      // re acts as a valid qualifier so the port shows zero instead of stale storage.
      assign rdata = re ? mem[raddr] : '0;
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with thresholds, exact fill count and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through (zero-latency) read data.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   fill_count,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int            DEPTH   = depth_of(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

  generate
    if (DATA_W < 1 || ADDR_W < 2 || AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
        AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_params
      $error("sync_fifo_param: illegal DATA_W/ADDR_W/AF_LEVEL/AE_LEVEL combination");
    end
  endgenerate

  logic [ADDR_W:0] wptr;
  logic [ADDR_W:0] rptr;
  logic            rd_ok;
  logic            wr_ok;
  logic            ram_re;
  fifo_status_t    status;

  // The extra wrap bit lets the plain difference span 0..DEPTH without ambiguity.
  assign fill_count = wptr - rptr;

  always_comb begin
    status              = '0;
    status.full         = (fill_count == DEPTH_C);
    status.empty        = (fill_count == '0);
    status.almost_full  = (fill_count >= AF_C);
    status.almost_empty = (fill_count <= AE_C);
  end

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;

  // A pop frees the slot in the same cycle, so a write at full is legal alongside it.
  assign rd_ok = rd & ~status.empty;
  assign wr_ok = wr & (~status.full | rd_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;

      if (wr && !wr_ok)  overflow <= 1'b1;
      else if (err_clr)  overflow <= 1'b0;

      if (rd && !rd_ok)  underflow <= 1'b1;
      else if (err_clr)  underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  localparam bit REG_RD = 1'b0;
  assign ram_re = ~status.empty;
`else
  localparam bit REG_RD = 1'b1;
  assign ram_re = rd_ok;
`endif

  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .REG_RD (REG_RD)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .waddr (wptr[ADDR_W-1:0]),
    .wdata (data_in),
    .re    (ram_re),
    .raddr (rptr[ADDR_W-1:0]),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param against a queue-based reference model;
// build with SYNC_FIFO_FWFT_EN defined to exercise first-word-fall-through.
module tb_sync_fifo_param;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int AF     = 12;
  localparam int AE     = 4;
`ifdef SYNC_FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr;
  logic              rd;
  logic              err_clr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   fill_count;
  logic              overflow;
  logic              underflow;
  logic [10:0]       dut_status;

  sync_fifo_param #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr           (wr),
    .data_in      (data_in),
    .rd           (rd),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fill_count   (fill_count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  assign dut_status = {full, empty, almost_full, almost_empty, overflow, underflow, fill_count};

  // Reference model: contents as a queue, sticky flags, last popped word.
  logic [DATA_W-1:0] q[$];
  bit                m_ovf;
  bit                m_udf;
  logic [DATA_W-1:0] m_dout;
  int                n_checks;
  int                n_pass;

  function automatic logic [10:0] model_status();
    int n = q.size();
    return {n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf, m_udf, 5'(n)};
  endfunction

  function automatic logic [DATA_W-1:0] model_dout();
    return FWFT ? q[0] : m_dout;
  endfunction

  function automatic bit dout_known();
    return !FWFT || q.size() != 0;
  endfunction

  // Drive one clock of stimulus and advance the model; returns 1 ns after the edge.
  task automatic cycle(input bit w, input bit r, input logic [DATA_W-1:0] d, input bit c);
    bit r_ok, w_ok;
    @(negedge clk);
    wr = w; rd = r; data_in = d; err_clr = c;
    @(posedge clk);
    r_ok = r && q.size() > 0;
    w_ok = w && (q.size() < DEPTH || r_ok);
    if (r_ok) m_dout = q.pop_front();
    if (w_ok) q.push_back(d);
    if (w && !w_ok) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (r && !r_ok) m_udf = 1'b1; else if (c) m_udf = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; data_in = '0;
    q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_dout = '0;
    #12;
    n_checks++;
    if (dut_status !== 11'b0_1_0_1_0_0_00000)
      $display("FAIL reset_status: got %b want %b", dut_status, 11'b0_1_0_1_0_0_00000);
    else n_pass++;
    if (!FWFT) begin
      n_checks++;
      if (data_out !== '0) $display("FAIL reset_data: got %h want 00", data_out);
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 1'b0, DATA_W'(i), 1'b0);
      n_checks++;
      if (dut_status !== model_status())
        $display("FAIL fill_status[%0d]: got %b want %b", i, dut_status, model_status());
      else n_pass++;
    end
    n_checks++;
    if (full !== 1'b1 || fill_count !== 5'd16)
      $display("FAIL fill_full: got full=%b count=%0d want full=1 count=16", full, fill_count);
    else n_pass++;
    cycle(1'b1, 1'b0, 8'hEE, 1'b0);
    n_checks++;
    if (overflow !== 1'b1 || fill_count !== 5'd16)
      $display("FAIL fill_overflow: got ovf=%b count=%0d want ovf=1 count=16", overflow, fill_count);
    else n_pass++;
  endtask

  task automatic test_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      if (FWFT) begin
        n_checks++;
        if (data_out !== DATA_W'(i)) $display("FAIL drain_fwft[%0d]: got %h want %h", i, data_out, DATA_W'(i));
        else n_pass++;
      end
      cycle(1'b0, 1'b1, '0, 1'b0);
      if (!FWFT) begin
        n_checks++;
        if (data_out !== DATA_W'(i)) $display("FAIL drain_reg[%0d]: got %h want %h", i, data_out, DATA_W'(i));
        else n_pass++;
      end
      n_checks++;
      if (dut_status !== model_status())
        $display("FAIL drain_status[%0d]: got %b want %b", i, dut_status, model_status());
      else n_pass++;
    end
    cycle(1'b0, 1'b1, '0, 1'b0);
    n_checks++;
    if (underflow !== 1'b1 || empty !== 1'b1)
      $display("FAIL drain_underflow: got udf=%b empty=%b want 1 1", underflow, empty);
    else n_pass++;
  endtask

  task automatic test_err_clr();
    cycle(1'b0, 1'b0, '0, 1'b1);
    n_checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0)
      $display("FAIL err_clr: got ovf=%b udf=%b want 0 0", overflow, underflow);
    else n_pass++;
  endtask

  task automatic test_full_simul();
    logic [DATA_W-1:0] head;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DATA_W'($urandom), 1'b0);
    head = q[0];
    cycle(1'b1, 1'b1, 8'hAA, 1'b0);
    n_checks++;
    if (fill_count !== 5'd16 || overflow !== 1'b0)
      $display("FAIL full_simul: got count=%0d ovf=%b want 16 0", fill_count, overflow);
    else n_pass++;
    n_checks++;
    if (data_out !== (FWFT ? q[0] : head))
      $display("FAIL full_simul_data: got %h want %h", data_out, FWFT ? q[0] : head);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, '0, 1'b0);
      n_checks++;
      if (dout_known() && data_out !== model_dout())
        $display("FAIL full_drain[%0d]: got %h want %h", i, data_out, model_dout());
      else n_pass++;
    end
    n_checks++;
    if (!FWFT && data_out !== 8'hAA) $display("FAIL full_last: got %h want aa", data_out);
    else n_pass++;
  endtask

  task automatic test_empty_simul();
    cycle(1'b1, 1'b1, 8'h55, 1'b0);
    n_checks++;
    if (fill_count !== 5'd1 || underflow !== 1'b1)
      $display("FAIL empty_simul: got count=%0d udf=%b want 1 1", fill_count, underflow);
    else n_pass++;
    if (FWFT) begin
      n_checks++;
      if (data_out !== 8'h55) $display("FAIL empty_simul_fwft: got %h want 55", data_out);
      else n_pass++;
    end
    cycle(1'b0, 1'b1, '0, 1'b0);
    if (!FWFT) begin
      n_checks++;
      if (data_out !== 8'h55) $display("FAIL empty_simul_reg: got %h want 55", data_out);
      else n_pass++;
    end
    n_checks++;
    if (dut_status !== model_status())
      $display("FAIL empty_simul_status: got %b want %b", dut_status, model_status());
    else n_pass++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b0, DATA_W'($urandom), 1'b0);
      if (FWFT) begin
        n_checks++;
        if (data_out !== q[0]) $display("FAIL wrap_fwft[%0d]: got %h want %h", i, data_out, q[0]);
        else n_pass++;
      end
      cycle(1'b0, 1'b1, '0, 1'b0);
      n_checks++;
      if ((dout_known() && data_out !== model_dout()) || dut_status !== model_status())
        $display("FAIL wrap_pair[%0d]: got %h/%b want %h/%b", i, data_out, dut_status,
                 model_dout(), model_status());
      else n_pass++;
    end
    for (int i = 0; i < 300; i++) begin
      int phase = (i / 50) % 2;
      bit w = ($urandom_range(99) < (phase ? 30 : 70));
      bit r = ($urandom_range(99) < (phase ? 70 : 30));
      cycle(w, r, DATA_W'($urandom), $urandom_range(15) == 0);
      n_checks++;
      if ((dout_known() && data_out !== model_dout()) || dut_status !== model_status() ||
          fill_count > 5'd16)
        $display("FAIL wrap_rand[%0d]: got %h/%b want %h/%b", i, data_out, dut_status,
                 model_dout(), model_status());
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    while (q.size() != 0) cycle(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, DATA_W'($urandom), 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    n_checks++;
    if (fill_count !== 5'd7) $display("FAIL mid_fill: got %0d want 7", fill_count);
    else n_pass++;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
    #2 rst_n = 1'b0;
    q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_dout = '0;
    #1;
    n_checks++;
    if (dut_status !== 11'b0_1_0_1_0_0_00000)
      $display("FAIL mid_reset_status: got %b want %b", dut_status, 11'b0_1_0_1_0_0_00000);
    else n_pass++;
    if (!FWFT) begin
      n_checks++;
      if (data_out !== '0) $display("FAIL mid_reset_data: got %h want 00", data_out);
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 8'h3C, 1'b0);
    if (FWFT) begin
      n_checks++;
      if (data_out !== 8'h3C) $display("FAIL mid_reset_fwft: got %h want 3c", data_out);
      else n_pass++;
    end
    cycle(1'b0, 1'b1, '0, 1'b0);
    if (!FWFT) begin
      n_checks++;
      if (data_out !== 8'h3C) $display("FAIL mid_reset_reg: got %h want 3c", data_out);
      else n_pass++;
    end
    n_checks++;
    if (dut_status !== model_status())
      $display("FAIL mid_reset_after: got %b want %b", dut_status, model_status());
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_fill();
    test_drain();
    test_err_clr();
    test_full_simul();
    test_err_clr();
    test_empty_simul();
    test_err_clr();
    test_wrap();
    test_err_clr();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
